uart_rx_mmio: RTL and testbench
===============================

# uart_rx_mmio

Memory-mapped UART receiver peripheral for the Hack computer. It deserialises 8N1 frames from the `UART_RX` pin and buffers the received bytes in a FIFO. The CPU reads and pops them through two registers decoded by the memory-mapped I/O block. It is the receive-side counterpart to the existing UART transmit path and the responder end of CPU memory accesses: it never initiates a transaction, it only answers reads and writes from the CPU.

## Interface

Parameters:
- `BAUD_DIV`, default 868: number of `CLK_100MHz` cycles per bit (115200 baud).
- `DEPTH`, default 16: FIFO depth in bytes. Must be a power of two, minimum 2.

Ports:
- `CLK_100MHz`, input, 1: the single clock for this block.
- `RESET`, input, 1: asynchronous, active-high reset.
- `CLK_CPU`, input, 1: CPU clock-enable pulse, one `CLK_100MHz` cycle wide.
- `UART_RX`, input, 1: serial line; idles high; asynchronous to the clock.
- `SEL`, input, 1: address decode hit for this peripheral.
- `REG`, input, 1: register select; 0 = DATA, 1 = STATUS.
- `LOAD_M`, input, 1: CPU write strobe.
- `DATA_W`, input, 16: CPU write data; its value is ignored.
- `DATA_R`, output, 16: read data; combinational from `REG` and internal state.

## Operation

- **Input synchroniser:** `UART_RX` passes through a 2-FF synchroniser. The FSM sees only the synchronised value, `rx_s`.
- **FSM states:** IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH.
  - IDLE: a falling edge on `rx_s` loads the bit counter with `BAUD_DIV/2 - 1` and moves to START.
  - START: at mid-bit, if `rx_s` = 0 go to DATA; otherwise the start was a glitch, return to IDLE.
  - DATA: sample 8 bits, LSB first, one every `BAUD_DIV` cycles.
  - Then go to PARITY (only when configured, see Configuration) or directly to STOP.
  - STOP at mid-bit, `rx_s` = 1: push the byte and go to IDLE.
  - STOP at mid-bit, `rx_s` = 0: framing error. Drop the byte, set `ferr`, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s` = 1, then go to IDLE. This keeps a break condition from producing repeated frames.
- **FIFO:**
  - Circular buffer with `log2(DEPTH)`-bit read/write pointers and a `log2(DEPTH)+1`-bit count.
  - Pointers wrap modulo `DEPTH`.
- **Push:** one cycle, on the cycle after the mid-stop sample.
  - If full and no pop in the same cycle: drop the byte and set `ovf`.
- **Pop:** occurs on a `CLK_100MHz` edge where `CLK_CPU && SEL && LOAD_M && REG==0`.
  - Popping an empty FIFO is ignored.
  - Push and pop in the same cycle, including when full or empty, both take effect. Count is unchanged and `ovf` is not set.
- **Clear flags:** a write with `CLK_CPU && SEL && LOAD_M && REG==1` clears `ovf`, `ferr` and `perr`.
  - If a flag is set in that same cycle, set wins.
- **DATA read** (`REG` = 0):
  - Not empty: `{8'h00, head_byte}`.
  - Empty: `16'h0000`.
- **STATUS read** (`REG` = 1):
  - bit 0: not-empty.
  - bit 1: `ovf`.
  - bit 2: `ferr`.
  - bit 3: `perr`.
  - bits 8 and up: count (`log2(DEPTH)+1` bits).
  - All other bits read 0.
- **`SEL` on reads:** `DATA_R` ignores `SEL`; the I/O block muxes it.

## Timing

- **Reset values:** FSM in IDLE, FIFO empty, pointers and count at 0, all flags 0, synchroniser FFs at 1.
  - Consequently `DATA_R` = `16'h0000` for both registers.
- **Reset mid-frame:** the partial byte is discarded. After reset is released, the next falling edge on the line starts a new frame.
- **Latency:** from the `UART_RX` falling edge to not-empty visible in STATUS is 2 + `BAUD_DIV/2` + 9·`BAUD_DIV` + 1 cycles, ±1.
  - Add `BAUD_DIV` with parity enabled.
- **Pop visibility:** after a pop, the next head byte appears on `DATA_R` in the following `CLK_100MHz` cycle, well before the next `CLK_CPU` pulse.
- **Throughput:** back-to-back frames with a single stop bit are received without loss.

## Configuration

- **`UART_RX_PARITY_EN` defined:** frames are 8E1.
  - The PARITY state samples a ninth bit.
  - If the XOR of the data bits and the parity bit is not 0, the byte is dropped and `perr` is set.
  - The FSM then still goes to STOP.
- **Not defined:** frames are 8N1. There is no PARITY state, and `perr`/status bit 3 is constant 0.

## Test plan

- **Single frame:** reset, then send 0xA5 at `BAUD_DIV`=868.
  - STATUS = `0x0101`, DATA = `0x00A5`.
  - Pop write, then STATUS = `0x0000` and DATA = `0x0000`.
- **Overflow:** send 17 bytes 0x00–0x10 without popping.
  - STATUS = `0x1003` (count 16, not-empty, `ovf`).
  - 16 pops return 0x00–0x0F in order; 0x10 is lost.
- **Framing error and break:** send 0x3C with stop bit = 0, then hold the line low for 3 frame times, then release and send 0x55.
  - 0x3C is not pushed and `ferr` = 1.
  - No further frames are pushed while the line is held low.
  - 0x55 is received.
  - A STATUS write then clears `ferr`.
- **Simultaneous push/pop when full:** fill the FIFO to 16, then align a pop with the push cycle of byte 0x77.
  - Count stays 16, `ovf` = 0, and 0x77 is the last byte read out.
- **Glitch and reset:**
  - A 100-cycle low pulse on `UART_RX` produces no push.
  - Asserting `RESET` during bit 4 of 0x81 produces STATUS = `0x0000`; a following 0x42 is received correctly.
- **Parity** (`UART_RX_PARITY_EN` defined):
  - 0x03 with parity bit 0 is accepted.
  - 0x03 with parity bit 1 is dropped and STATUS bit 3 = 1.

Source files
------------

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: memory-mapped UART receiver (8N1) with a byte FIFO read by the Hack CPU.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
module uart_rx_mmio #(
  parameter int BAUD_DIV = 868,
  parameter int DEPTH    = 16
) (
  input  logic        CLK_100MHz,
  input  logic        RESET,
  input  logic        CLK_CPU,
  input  logic        UART_RX,
  input  logic        SEL,
  input  logic        REG,
  input  logic        LOAD_M,
  input  logic [15:0] DATA_W,
  output logic [15:0] DATA_R
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  function automatic logic parity_odd(input logic [8:0] bits);
    return ^bits;
  endfunction

  logic          sync1, rx_s, rx_prev;
  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          load_half, load_full, shift_en, par_sample, stop_ok, stop_bad;
  logic          par_err_now, par_bad;
  logic          push_req;
  logic [7:0]    push_data;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, pop_req, clr_req, do_push, do_pop, set_ovf;
  logic          ovf, ferr, perr;
  logic [15:0]   status;
  logic          unused_data_w;

  assign unused_data_w = ^DATA_W;
  assign tick          = (cnt == {CW{1'b0}});
  // In 8N1 builds par_sample is never raised, so perr stays 0.
  assign par_err_now   = par_sample && parity_odd({rx_s, shift});

  // Two-stage synchroniser plus previous-value register for start-edge detection.
  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= UART_RX;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  // Receiver state register.
  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-cycle datapath controls.
  always_comb begin
    state_next = state;
    load_half  = 1'b0;
    load_full  = 1'b0;
    shift_en   = 1'b0;
    par_sample = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_next = START;
          load_half  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            state_next = DATA;
            load_full  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (tick) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
          if (bit_idx == 3'd7) begin
            state_next = AFTER_DATA;
          end else begin
            state_next = DATA;
          end
        end else begin
          state_next = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_sample = 1'b1;
          load_full  = 1'b1;
          state_next = STOP;
        end else begin
          state_next = PARITY;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            stop_ok    = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = WAIT_HIGH;
          end
        end else begin
          state_next = STOP;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_HIGH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bit timer, shift register and the registered push request.
  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      cnt       <= {CW{1'b0}};
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      par_bad   <= 1'b0;
      push_req  <= 1'b0;
      push_data <= 8'h00;
    end else begin
      if (load_half) begin
        cnt <= HALF_LOAD;
      end else if (load_full) begin
        cnt <= FULL_LOAD;
      end else if (!tick) begin
        cnt <= cnt - CW'(1);
      end
      if (load_half) begin
        bit_idx <= 3'd0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (shift_en) begin
        shift <= {rx_s, shift[7:1]};
      end
      if (load_half) begin
        par_bad <= 1'b0;
      end else if (par_err_now) begin
        par_bad <= 1'b1;
      end
      push_req  <= stop_ok && !par_bad;
      push_data <= shift;
    end
  end

  assign pop_req = CLK_CPU && SEL && LOAD_M && !REG;
  assign clr_req = CLK_CPU && SEL && LOAD_M && REG;
  assign empty   = (count == {(AW + 1){1'b0}});
  assign full    = (count == (AW + 1)'(DEPTH));
  // A simultaneous pop frees the slot, and a push supplies the byte, so both proceed.
  assign do_push = push_req && (!full || pop_req);
  assign do_pop  = pop_req && (!empty || push_req);
  assign set_ovf = push_req && full && !pop_req;

  // FIFO storage.
  always_ff @(posedge CLK_100MHz) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers, occupancy and sticky error flags.
  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW + 1){1'b0}};
      ovf    <= 1'b0;
      ferr   <= 1'b0;
      perr   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (set_ovf) begin
        ovf <= 1'b1;
      end else if (clr_req) begin
        ovf <= 1'b0;
      end
      if (stop_bad) begin
        ferr <= 1'b1;
      end else if (clr_req) begin
        ferr <= 1'b0;
      end
      if (par_err_now) begin
        perr <= 1'b1;
      end else if (clr_req) begin
        perr <= 1'b0;
      end
    end
  end

  // Read mux: DATA shows the head byte, STATUS packs flags and count.
  always_comb begin
    status            = 16'h0000;
    status[0]         = !empty;
    status[1]         = ovf;
    status[2]         = ferr;
    status[3]         = perr;
    status[8 +: AW+1] = count;
    if (REG) begin
      DATA_R = status;
    end else if (!empty) begin
      DATA_R = {8'h00, mem[rd_ptr]};
    end else begin
      DATA_R = 16'h0000;
    end
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Scoreboard bench for uart_rx_mmio: serial frames feed a queue-based model, a monitor
// compares every CPU read of DATA_R against the value queued when the read was issued.
module tb_uart_rx_mmio;

  localparam int B     = 32;
  localparam int DEPTH = 16;
  // Cycles from driving the start bit low until the cycle in which the byte is pushed.
`ifdef UART_RX_PARITY_EN
  localparam int PUSH_LAT = 3 + B / 2 + 10 * B;
`else
  localparam int PUSH_LAT = 3 + B / 2 + 9 * B;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_cpu;
  logic        rx;
  logic        sel;
  logic        reg_sel;
  logic        load_m;
  logic [15:0] data_w;
  logic [15:0] data_r;
  logic        rd_req;

  int checks = 0;
  int errors = 0;

  logic [7:0]  fifo_m[$];
  logic        ovf_m, ferr_m, perr_m;
  logic [15:0] exp_val[$];
  string       exp_tag[$];
  logic [15:0] ev;
  string       tg;

  uart_rx_mmio #(.BAUD_DIV(B), .DEPTH(DEPTH)) dut (
    .CLK_100MHz(clk),
    .RESET     (rst),
    .CLK_CPU   (clk_cpu),
    .UART_RX   (rx),
    .SEL       (sel),
    .REG       (reg_sel),
    .LOAD_M    (load_m),
    .DATA_W    (data_w),
    .DATA_R    (data_r)
  );

  always #5 clk = ~clk;

  // Monitor: every read cycle consumes one expected value.
  always @(negedge clk) begin
    if (rd_req) begin
      checks++;
      if (exp_val.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: read with no expected value, got %h", data_r);
      end else begin
        ev = exp_val.pop_front();
        tg = exp_tag.pop_front();
        if (data_r !== ev) begin
          errors++;
          $display("FAIL %s: got %h expected %h at %0t", tg, data_r, ev, $time);
        end
      end
    end
  end

  function automatic void model_reset();
    fifo_m.delete();
    ovf_m  = 1'b0;
    ferr_m = 1'b0;
    perr_m = 1'b0;
  endfunction

  function automatic void model_push(input logic [7:0] d);
    if (fifo_m.size() == DEPTH) ovf_m = 1'b1;
    else fifo_m.push_back(d);
  endfunction

  function automatic logic [15:0] status_m();
    logic [15:0] s;
    s        = 16'h0000;
    s[0]     = (fifo_m.size() != 0);
    s[1]     = ovf_m;
    s[2]     = ferr_m;
    s[3]     = perr_m;
    s[15:8]  = 8'(fifo_m.size());
    return s;
  endfunction

  function automatic logic [15:0] data_m();
    if (fifo_m.size() != 0) return {8'h00, fifo_m[0]};
    else return 16'h0000;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    rx = 1'b0;
    wait_cycles(B);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(B);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    wait_cycles(B);
    if (par_flip) perr_m = 1'b1;
`endif
    rx = stop_bit;
    wait_cycles(B);
    if (!stop_bit) ferr_m = 1'b1;
    else if (!par_flip) model_push(d);
  endtask

  task automatic cpu_read(input logic r, input string name);
    reg_sel = r;
    sel     = 1'b1;
    rd_req  = 1'b1;
    exp_val.push_back(r ? status_m() : data_m());
    exp_tag.push_back(name);
    wait_cycles(1);
    sel    = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic cpu_pop(input string name);
    reg_sel = 1'b0;
    sel     = 1'b1;
    load_m  = 1'b1;
    clk_cpu = 1'b1;
    rd_req  = 1'b1;
    data_w  = 16'($urandom);
    exp_val.push_back(data_m());
    exp_tag.push_back(name);
    wait_cycles(1);
    sel     = 1'b0;
    load_m  = 1'b0;
    clk_cpu = 1'b0;
    rd_req  = 1'b0;
    if (fifo_m.size() != 0) void'(fifo_m.pop_front());
  endtask

  task automatic cpu_clear();
    reg_sel = 1'b1;
    sel     = 1'b1;
    load_m  = 1'b1;
    clk_cpu = 1'b1;
    wait_cycles(1);
    sel     = 1'b0;
    load_m  = 1'b0;
    clk_cpu = 1'b0;
    ovf_m   = 1'b0;
    ferr_m  = 1'b0;
    perr_m  = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] d81;
    int n;
    rst = 1'b1; rx = 1'b1; clk_cpu = 1'b0; sel = 1'b0; reg_sel = 1'b0;
    load_m = 1'b0; data_w = 16'hFFFF; rd_req = 1'b0;
    model_reset();
    wait_cycles(4);
    rst = 1'b0;
    wait_cycles(2);
    cpu_read(1'b1, "reset_status");
    cpu_read(1'b0, "reset_data");

    // Single frame
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_cycles(4);
    cpu_read(1'b1, "single_status");
    cpu_read(1'b0, "single_data");
    cpu_pop("single_pop");
    cpu_read(1'b1, "single_status_after_pop");
    cpu_read(1'b0, "single_data_after_pop");

    // Random back-to-back bursts
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom_range(0, 255));
        send_frame(b, 1'b1, 1'b0);
      end
      wait_cycles(4);
      cpu_read(1'b1, "burst_status");
      for (int k = 0; k < n; k++) cpu_pop("burst_pop");
      cpu_read(1'b1, "burst_status_empty");
    end

    // Overflow: 17 bytes into a 16-deep FIFO
    for (int k = 0; k <= 16; k++) send_frame(8'(k), 1'b1, 1'b0);
    wait_cycles(4);
    cpu_read(1'b1, "ovf_status");
    for (int k = 0; k < 16; k++) cpu_pop("ovf_pop");
    cpu_read(1'b1, "ovf_status_drained");
    cpu_clear();
    cpu_read(1'b1, "ovf_status_cleared");

    // Framing error then break held for three frame times
    send_frame(8'h3C, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_cycles(10 * B);
      cpu_read(1'b1, "break_status");
    end
    rx = 1'b1;
    wait_cycles(2 * B);
    send_frame(8'h55, 1'b1, 1'b0);
    wait_cycles(4);
    cpu_read(1'b1, "ferr_status_after_55");
    cpu_pop("ferr_pop_55");
    cpu_clear();
    cpu_read(1'b1, "ferr_cleared");

    // Push aligned with a pop while full
    for (int k = 0; k < 16; k++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    wait_cycles(4);
    cpu_read(1'b1, "full_status");
    fork
      send_frame(8'h77, 1'b1, 1'b0);
      begin
        repeat (PUSH_LAT) @(posedge clk);
        #1;
        cpu_pop("simul_pop");
      end
    join
    wait_cycles(4);
    cpu_read(1'b1, "simul_status");
    for (int k = 0; k < 16; k++) cpu_pop("simul_drain");
    cpu_read(1'b1, "simul_empty");

    // Short glitch on the line
    rx = 1'b0;
    wait_cycles(B / 4);
    rx = 1'b1;
    wait_cycles(2 * B);
    cpu_read(1'b1, "glitch_status");
    b = 8'($urandom_range(0, 255));
    send_frame(b, 1'b1, 1'b0);
    wait_cycles(4);
    cpu_pop("post_glitch_pop");

    // Reset during bit 4 of 0x81, released while the line is high in bit 7
    d81 = 8'h81;
    rx = 1'b0;
    wait_cycles(B);
    for (int i = 0; i < 4; i++) begin
      rx = d81[i];
      wait_cycles(B);
    end
    rx = d81[4];
    wait_cycles(B / 2);
    rst = 1'b1;
    model_reset();
    wait_cycles(B / 2);
    for (int i = 5; i < 7; i++) begin
      rx = d81[i];
      wait_cycles(B);
    end
    rx = d81[7];
    wait_cycles(B / 2);
    rst = 1'b0;
    wait_cycles(B / 2);
    rx = 1'b1;
    wait_cycles(2 * B);
    cpu_read(1'b1, "midreset_status");
    cpu_read(1'b0, "midreset_data");
    send_frame(8'h42, 1'b1, 1'b0);
    wait_cycles(4);
    cpu_read(1'b1, "after_reset_status");
    cpu_pop("after_reset_pop");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b0);
    wait_cycles(4);
    cpu_read(1'b1, "parity_good_status");
    cpu_pop("parity_good_pop");
    send_frame(8'h03, 1'b1, 1'b1);
    wait_cycles(4);
    cpu_read(1'b1, "parity_bad_status");
    cpu_clear();
    cpu_read(1'b1, "parity_cleared");
`endif

    wait_cycles(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
